// File: rtl/score_digit_scanner_if.sv
// Score-to-display bundle: binary score strobe in, busy/overflow status and scanned digit bus out.
// Latency: none, signal grouping only.
// Backpressure: none; a strobe is always accepted and busy is status only.
// Ports (per modport):
//   master : drives score, score_valid; observes busy, overflow, digit_num, an_out
//   slave  : receives score, score_valid; drives busy, overflow, digit_num, an_out
interface score_digit_scanner_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               busy;
    logic               overflow;
    logic [3:0]         digit_num;
    logic [3:0]         an_out;

    modport master (
        output score, score_valid,
        input  busy, overflow, digit_num, an_out
    );

    modport slave (
        input  score, score_valid,
        output busy, overflow, digit_num, an_out
    );
endinterface

// File: rtl/score_digit_scanner.sv
// Binary score -> 4 BCD digits (sequential double-dabble) -> time-multiplexed digit bus + active-low anodes.
// Latency: strobe at edge N, display regs load at N+15, digit bus shows the new value from N+16 on.
// Backpressure: none; strobes during a conversion land in a one-entry holding reg (latest wins).
// Ports: clk, rst (sync, active-high), bus (slave): score/score_valid in; busy, overflow,
//        digit_num (BCD to decoder), an_out (one-hot-low anodes, bit0 = units) out.
// Option: define SCORE_BLANK_LEADING_ZERO_EN to blank digits above the most significant nonzero one.
module score_digit_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int SCORE_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    score_digit_scanner_if.slave  bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] ITER_LAST = 4'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] SAT_MAX = SCORE_W'(9999);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t             state;
    logic [SCORE_W-1:0] bin;
    logic [15:0]        bcd;
    logic [3:0]         iter;
    logic               ovf_cur;
    logic [SCORE_W-1:0] hold_val;
    logic               hold_ovf;
    logic               pending;
    logic [15:0]        disp;
    logic               busy_r;
    logic               ovf_r;

    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         digit_sel;
    logic [3:0]         digit_r;
    logic [3:0]         an_r;

    logic [SCORE_W-1:0] sat_val;
    logic               sat_ovf;
    logic [15:0]        bcd_adj;
    logic [3:0]         digit_next;
    logic [3:0]         an_next;

    // Saturate anything above 9999 so four BCD digits always suffice.
    always_comb begin
        sat_ovf = (bus.score > SAT_MAX);
        sat_val = sat_ovf ? SAT_MAX : bus.score;
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            iter     <= '0;
            ovf_cur  <= 1'b0;
            hold_val <= '0;
            hold_ovf <= 1'b0;
            pending  <= 1'b0;
            disp     <= '0;
            busy_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.score_valid) begin
                        bin     <= sat_val;
                        bcd     <= '0;
                        ovf_cur <= sat_ovf;
                        iter    <= '0;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[14:0], bin[SCORE_W-1]};
                    bin  <= {bin[SCORE_W-2:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == ITER_LAST)
                        state <= LOAD;
                    if (bus.score_valid) begin
                        hold_val <= sat_val;
                        hold_ovf <= sat_ovf;
                        pending  <= 1'b1;
                    end
                end
                LOAD: begin
                    disp  <= bcd;
                    ovf_r <= ovf_cur;
                    // A strobe landing on LOAD is newer than anything held, so it wins.
                    if (bus.score_valid) begin
                        bin     <= sat_val;
                        ovf_cur <= sat_ovf;
                        bcd     <= '0;
                        iter    <= '0;
                        pending <= 1'b0;
                        state   <= SHIFT;
                    end else if (pending) begin
                        bin     <= hold_val;
                        ovf_cur <= hold_ovf;
                        bcd     <= '0;
                        iter    <= '0;
                        pending <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        digit_next = 4'd0;
        case (digit_sel)
            2'd0: digit_next = disp[3:0];
            2'd1: digit_next = disp[7:4];
            2'd2: digit_next = disp[11:8];
            2'd3: digit_next = disp[15:12];
            default: digit_next = 4'd0;
        endcase
        an_next = ~(4'b0001 << digit_sel);
`ifdef SCORE_BLANK_LEADING_ZERO_EN
        // A slot is lit if it or any higher digit is nonzero; units always lit.
        if ((digit_sel == 2'd1 && disp[15:4]  == 12'd0) ||
            (digit_sel == 2'd2 && disp[15:8]  == 8'd0)  ||
            (digit_sel == 2'd3 && disp[15:12] == 4'd0))
            an_next = 4'b1111;
`endif
    end

    // Free-running scan, never stalled or realigned by conversions.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_sel <= 2'd0;
            digit_r   <= 4'd0;
            an_r      <= 4'b1111;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            digit_r <= digit_next;
            an_r    <= an_next;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.overflow  = ovf_r;
    assign bus.digit_num = digit_r;
    assign bus.an_out    = an_r;
endmodule

// File: tb/tb_score_digit_scanner.sv
module tb_score_digit_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    score_digit_scanner_if #(.SCORE_W(14)) bus ();

    score_digit_scanner #(.SCAN_DIV(4), .SCORE_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [13:0] score;
        int          exp_val;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        int val;
        bit ovf;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Strobe v0 at edge N, optional extra strobes at edges N+c1 / N+c2.
    // Returns consecutive busy cycles seen from N, whether digit 2 ever showed, digit at N+20.
    task automatic conv(input logic [13:0] v0, input int c1, input logic [13:0] v1,
                        input int c2, input logic [13:0] v2,
                        output int bcnt, output bit saw2, output int mid_dig);
        bit done;
        @(negedge clk);
        bus.score = v0;
        bus.score_valid = 1'b1;
        @(negedge clk);
        bus.score_valid = 1'b0;
        bcnt = 0; saw2 = 0; mid_dig = -1; done = 0;
        for (int c = 0; c < 80; c++) begin
            if (!done) begin
                if (bus.busy) bcnt++;
                else done = 1;
            end
            if (bus.digit_num == 4'd2) saw2 = 1;
            if (c == 20) mid_dig = int'(bus.digit_num);
            if (done && c >= c1 && c >= c2) break;
            if (c + 1 == c1) begin
                bus.score = v1; bus.score_valid = 1'b1;
            end else if (c + 1 == c2) begin
                bus.score = v2; bus.score_valid = 1'b1;
            end else begin
                bus.score_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.score_valid = 1'b0;
    endtask

    // Pops the next expected display and watches a full scan round.
    task automatic check_display(input string name);
        exp_t e;
        int dig[4];
        bit lit[4];
        bit seen[4];
        int bad;
        int p;
        if (sb.size() == 0) begin
            chk({name, " scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        p = 1;
        for (int k = 0; k < 4; k++) begin
            dig[k] = (e.val / p) % 10;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
            lit[k] = (k == 0) || (e.val >= p);
`else
            lit[k] = 1'b1;
`endif
            seen[k] = 1'b0;
            p = p * 10;
        end
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            case (bus.an_out)
                4'b1110: begin seen[0] = 1; if (int'(bus.digit_num) != dig[0]) bad++; end
                4'b1101: begin seen[1] = 1; if (int'(bus.digit_num) != dig[1]) bad++; end
                4'b1011: begin seen[2] = 1; if (int'(bus.digit_num) != dig[2]) bad++; end
                4'b0111: begin seen[3] = 1; if (int'(bus.digit_num) != dig[3]) bad++; end
                4'b1111: ;
                default: bad++;
            endcase
            @(negedge clk);
        end
        chk({name, " bad_digit_samples"}, bad, 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s slot%0d_lit", name, k), int'(seen[k]), int'(lit[k]));
        chk({name, " overflow"}, int'(bus.overflow), int'(e.ovf));
    endtask

    initial begin
        vec_t tbl[9];
        int bcnt;
        bit saw2;
        int mid;
        logic [3:0] exp_an;

        tbl[0] = '{14'd1234,  1234, 1'b0};
        tbl[1] = '{14'd12000, 9999, 1'b1};
        tbl[2] = '{14'd7,     7,    1'b0};
        tbl[3] = '{14'd9999,  9999, 1'b0};
        tbl[4] = '{14'd10000, 9999, 1'b1};
        tbl[5] = '{14'd0,     0,    1'b0};
        tbl[6] = '{14'd42,    42,   1'b0};
        tbl[7] = '{14'd16383, 9999, 1'b1};
        tbl[8] = '{14'd905,   905,  1'b0};

        bus.score = '0;
        bus.score_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset overflow", int'(bus.overflow), 0);
        chk("reset digit_num", int'(bus.digit_num), 0);
        chk("reset an_out", int'(bus.an_out), 4'b1111);

        // Idle scan: each anode held 4 cycles, all digits 0.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << (i / 4));
`ifdef SCORE_BLANK_LEADING_ZERO_EN
            if (i >= 4) exp_an = 4'b1111;
`endif
            chk($sformatf("idle an_out[%0d]", i), int'(bus.an_out), int'(exp_an));
            chk($sformatf("idle digit[%0d]", i), int'(bus.digit_num), 0);
        end
        chk("idle busy", int'(bus.busy), 0);

        for (int i = 0; i < 9; i++) begin
            sb.push_back('{tbl[i].exp_val, tbl[i].exp_ovf});
            conv(tbl[i].score, -1, '0, -1, '0, bcnt, saw2, mid);
            chk($sformatf("vec%0d busy_cycles", i), bcnt, 15);
            check_display($sformatf("vec%0d", i));
        end

        // Back-to-back: 1111 at N, 2222 at N+3, 3333 at N+5.
        sb.push_back('{3333, 1'b0});
        conv(14'd1111, 3, 14'd2222, 5, 14'd3333, bcnt, saw2, mid);
        chk("b2b busy_cycles", bcnt, 30);
        chk("b2b saw_2222", int'(saw2), 0);
        chk("b2b mid_digit_1111", mid, 1);
        check_display("b2b final");

        // Strobe coinciding with LOAD converts with no idle cycle.
        sb.push_back('{6, 1'b0});
        conv(14'd5, 15, 14'd6, -1, '0, bcnt, saw2, mid);
        chk("load_strobe busy_cycles", bcnt, 30);
        check_display("load_strobe");

        // Reset mid-conversion (sampled at SHIFT iteration 7).
        @(negedge clk);
        bus.score = 14'd5678;
        bus.score_valid = 1'b1;
        @(negedge clk);
        bus.score_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort overflow", int'(bus.overflow), 0);
        chk("abort digit_num", int'(bus.digit_num), 0);
        chk("abort an_out", int'(bus.an_out), 4'b1111);
        rst = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
        end
        chk("abort busy_after", bcnt, 0);
        sb.push_back('{0, 1'b0});
        check_display("abort display");

        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/score_digit_scanner.md
Name: score_digit_scanner

Overview:
- Sits directly upstream of the seven-segment decoder in the Snake display path.
- Takes the binary game score and converts it to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto a single 4-bit digit bus that feeds the decoder's num input, and drives the active-low digit anodes.
- Decouples score updates from the display refresh. The displayed value changes atomically, only when a conversion completes.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit. Legal range is 2..2^20. Use 4 in simulation.
- SCORE_W, 14: score input width. Fixed at 14; other values are not supported.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- score  in  14  binary score, sampled when score_valid=1
- score_valid  in  1  single-cycle strobe: new score available
- busy  out  1  high while a conversion is pending or in progress
- overflow  out  1  high while the displayed score was saturated (input >9999)
- digit_num  out  4  BCD digit 0..9 to the decoder num input
- an_out  out  4  digit anodes, active-low, one-hot-low; bit0 = units

Behaviour:
- Reset: clk and rst only; rst is sampled at clk edges.
  - While rst=1, outputs are: digit_num=0, an_out=4'b1111, busy=0, overflow=0.
  - Internal state clears: display regs 0000, digit_sel=0, div_cnt=0, FSM in IDLE, pending=0.
- Conversion FSM states:
  - IDLE: on score_valid=1, capture score into shift reg and go to SHIFT.
    - If score>9999, capture 9999 and set ovf_next=1; otherwise ovf_next=0.
  - SHIFT: 14 iterations, one per clock. Each iteration adds 3 to any BCD nibble >=5, then shifts {bcd,bin} left by 1. After the 14th iteration go to LOAD.
  - LOAD: copy the 16-bit BCD into the display regs, copy ovf_next into overflow, then return to IDLE. If pending=1, clear pending and go straight to SHIFT using the held value.
- Latency: strobe at edge N, so SHIFT runs N+1..N+14, LOAD at N+15. New digits appear on digit_num from the first digit update at or after N+16.
- busy:
  - Rises the cycle after an accepted strobe.
  - Falls the cycle after LOAD when nothing is pending.
  - Stays high across back-to-back conversions.
- score_valid while busy: the value (after saturation) is stored in a one-entry holding reg and pending=1.
  - A later strobe overwrites the holding reg: latest value wins.
  - No strobe is ever dropped silently; intermediate values may be skipped.
- score_valid in the same cycle as LOAD: treated as pending. It is converted immediately after LOAD, with no idle cycle.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - At div_cnt=SCAN_DIV-1, digit_sel advances 0->1->2->3->0.
  - digit_num and an_out are registered from digit_sel and the display regs, so they lag digit_sel by 1 cycle.
  - Anode patterns: an_out = 1110, 1101, 1011, 0111 for digit_sel 0..3.
- Scan is independent of conversion: no stall and no reset of div_cnt on new scores.
- Display regs change only in LOAD, so no partial value is ever shown.
- rst asserted mid-conversion aborts the conversion and clears pending. The aborted value is never displayed.

Optional Feature:
- Macro: SCORE_BLANK_LEADING_ZERO_EN.
- Defined: digits above the most significant nonzero digit are blanked by forcing their an_out bit to 1. digit_num still carries 0 for those slots. The units digit is never blanked, so score 0 shows a single "0". Blanking is evaluated from the display regs, with the same 1-cycle registered timing.
- Undefined: all four digits are always lit, zero-padded (e.g. 0042).

Test Plan:
- Reset then idle, SCAN_DIV=4 -> an_out cycles 1110,1101,1011,0111, each held 4 cycles; digit_num=0 throughout; busy=0.
- score=1234 with a 1-cycle strobe -> busy high for 15 cycles; afterwards digit_num=4,3,2,1 with an_out 1110,1101,1011,0111; overflow=0.
- score=12000 -> display 9,9,9,9, overflow=1. A following score=7 -> overflow=0, digits 7,0,0,0.
- Strobe 1111 at edge N, 2222 at N+3, 3333 at N+5 -> 1111 displayed at LOAD, then 3333 without an idle cycle; 2222 never shown; busy continuous.
- rst pulsed at SHIFT iteration 7 of a 5678 conversion -> outputs return to reset values; display stays 0000; busy=0.
- With SCORE_BLANK_LEADING_ZERO_EN: score=42 -> an_out never shows 1011 or 0111 (stays 1111 in those slots); score=0 -> only units lit.
